// File: rtl/prog_tick_gen.sv
// Programmable terminal-count tick generator: WIDTH-bit up-counter with a run-time
// loadable period, periodic/one-shot modes, pause gating and a registered tick.
module prog_tick_gen #(
    parameter int WIDTH        = 8,
    parameter int RESET_PERIOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    output logic             out,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_P = WIDTH'(RESET_PERIOD);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] p_act_q, p_act_d;
    logic [WIDTH-1:0] p_pend_q, p_pend_d;
    logic             pend_q, pend_d;
    logic             mode_q, mode_d;
    logic             out_q, out_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] p_next;
    logic             wrap;

    // Period adopted at a period boundary: a same-cycle load beats any older pending value.
    always_comb begin
        p_next = load ? period_in : (pend_q ? p_pend_q : p_act_q);
        wrap   = (state_q == ST_RUN) && en && !stop && (p_act_q != '0)
                 && (count_q == p_act_q - ONE);
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        p_act_d  = p_act_q;
        p_pend_d = p_pend_q;
        pend_d   = pend_q;
        mode_d   = mode_q;
        out_d    = 1'b0;
        done_d   = done_q;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (load) begin
                    p_act_d = period_in;
                end
                // Acceptance looks at the period already active, not one loaded this cycle.
                if (start && (p_act_q != '0)) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (load) begin
                    p_pend_d = period_in;
                    pend_d   = 1'b1;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    p_act_d = p_next;
                    pend_d  = 1'b0;
                end else if (wrap) begin
                    count_d = '0;
                    out_d   = 1'b1;
                    p_act_d = p_next;
                    pend_d  = 1'b0;
                    if (mode_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (p_next == '0) begin
                        state_d = ST_IDLE;
                    end
                end else if (en) begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            p_act_q  <= RESET_P;
            p_pend_q <= '0;
            pend_q   <= 1'b0;
            mode_q   <= 1'b0;
            out_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            p_act_q  <= p_act_d;
            p_pend_q <= p_pend_d;
            pend_q   <= pend_d;
            mode_q   <= mode_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end

    assign out   = out_q;
    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;

endmodule

// File: tb/tb_prog_tick_gen.sv
// Bench for prog_tick_gen: directed scenarios then random traffic, every cycle
// compared against a behavioural model of elapsed-cycles and a pending-period queue.
module tb_prog_tick_gen;

    localparam int WIDTH        = 8;
    localparam int RESET_PERIOD = 10;

    logic             clk = 1'b0;
    logic             rst, en, start, stop, mode, load;
    logic [WIDTH-1:0] period_in;
    logic             out, busy, done;
    logic [WIDTH-1:0] count;

    int n_chk = 0;
    int n_err = 0;
    int cyc_no = 0;

    // Behavioural model: elapsed enabled cycles in the current period, queued next period.
    bit m_run, m_oneshot, m_out, m_done;
    int m_elapsed, m_period;
    int m_pend[$];

    always #5 clk = ~clk;

    prog_tick_gen #(
        .WIDTH       (WIDTH),
        .RESET_PERIOD(RESET_PERIOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .load     (load),
        .period_in(period_in),
        .out      (out),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    task automatic model_update(input bit r, e, s, p, m, l, input int pi);
        if (r) begin
            m_run = 0; m_elapsed = 0; m_out = 0; m_done = 0; m_oneshot = 0;
            m_period = RESET_PERIOD;
            m_pend.delete();
        end else if (!m_run) begin
            m_out = 0;
            if (s && m_period != 0) begin
                m_run = 1; m_elapsed = 0; m_oneshot = m; m_done = 0;
            end
            if (l) m_period = pi;
        end else begin
            m_out = 0;
            if (l) begin
                m_pend.delete();
                m_pend.push_back(pi);
            end
            if (p) begin
                m_run = 0; m_elapsed = 0;
                if (m_pend.size() > 0) m_period = m_pend.pop_front();
            end else if (e) begin
                if (m_elapsed + 1 == m_period) begin
                    m_out = 1; m_elapsed = 0;
                    if (m_pend.size() > 0) m_period = m_pend.pop_front();
                    if (m_oneshot) begin
                        m_run = 0; m_done = 1;
                    end else if (m_period == 0) begin
                        m_run = 0;
                    end
                end else begin
                    m_elapsed = (m_elapsed + 1) % (1 << WIDTH);
                end
            end
        end
    endtask

    task automatic step(input bit r, e, s, p, m, l, input int pi);
        rst = r; en = e; start = s; stop = p; mode = m; load = l;
        period_in = WIDTH'(pi);
        @(posedge clk);
        model_update(r, e, s, p, m, l, pi);
        #1;
        cyc_no++;
        chk("model_out", {31'b0, out}, {31'b0, m_out});
        chk("model_busy", {31'b0, busy}, {31'b0, m_run});
        chk("model_done", {31'b0, done}, {31'b0, m_done});
        chk("model_count", {24'b0, count}, m_elapsed);
        $display("cyc %0d rst=%0b en=%0b start=%0b stop=%0b mode=%0b load=%0b pin=%0d | out=%0b busy=%0b done=%0b count=%0d",
                 cyc_no, r, e, s, p, m, l, pi, out, busy, done, count);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; load = 1'b0;
        period_in = '0;
        m_run = 0; m_oneshot = 0; m_out = 0; m_done = 0; m_elapsed = 0;
        m_period = RESET_PERIOD;

        // Reset state
        step(1, 1, 0, 0, 0, 0, 0);
        chk("rst_out", {31'b0, out}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_count", {24'b0, count}, 0);

        // Periodic with reset period 10: ticks at t+11, t+21, t+31
        for (int k = 1; k <= 31; k++) begin
            step(0, 1, (k == 1), 0, 0, 0, 0);
            chk("p10_out", {31'b0, out}, ((k % 10 == 1) && (k > 1)) ? 1 : 0);
            chk("p10_count", {24'b0, count}, (k - 1) % 10);
            chk("p10_done", {31'b0, done}, 0);
        end
        step(0, 1, 0, 1, 0, 0, 0);
        chk("stop_busy", {31'b0, busy}, 0);

        // One-shot with P=4
        step(0, 1, 0, 0, 0, 1, 4);
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, (k == 1), 0, 1, 0, 0);
            chk("os4_out", {31'b0, out}, (k == 5) ? 1 : 0);
            chk("os4_done", {31'b0, done}, (k >= 5) ? 1 : 0);
            chk("os4_busy", {31'b0, busy}, (k < 5) ? 1 : 0);
            chk("os4_count", {24'b0, count}, (k < 5) ? k - 1 : 0);
        end
        step(0, 1, 1, 0, 0, 0, 0);
        chk("restart_done_clr", {31'b0, done}, 0);
        chk("restart_busy", {31'b0, busy}, 1);
        step(0, 1, 0, 1, 0, 0, 0);

        // Load 3 mid-period of P=10
        step(0, 1, 0, 0, 0, 1, 10);
        for (int k = 1; k <= 18; k++) begin
            step(0, 1, (k == 1), 0, 0, (k == 7), 3);
            chk("pend_out", {31'b0, out}, (k == 11 || k == 14 || k == 17) ? 1 : 0);
        end
        step(0, 1, 0, 1, 0, 0, 0);

        // Pause for 4 cycles at count 2 of P=6
        step(0, 1, 0, 0, 0, 1, 6);
        for (int k = 1; k <= 12; k++) begin
            step(0, !(k >= 4 && k <= 7), (k == 1), 0, 0, 0, 0);
            chk("pause_out", {31'b0, out}, (k == 11) ? 1 : 0);
            if (k >= 4 && k <= 7) chk("pause_count", {24'b0, count}, 2);
        end
        step(0, 1, 0, 1, 0, 0, 0);

        // Stop together with start on the wrap cycle of P=5
        step(0, 1, 0, 0, 0, 1, 5);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, (k == 1 || k == 6), (k == 6), 0, 0, 0);
            chk("stopwrap_out", {31'b0, out}, 0);
            chk("stopwrap_busy", {31'b0, busy}, (k < 6) ? 1 : 0);
            chk("stopwrap_count", {24'b0, count}, (k < 6) ? k - 1 : 0);
        end

        // Reset mid-period of a one-shot, with other inputs active
        step(0, 1, 0, 0, 0, 1, 10);
        for (int k = 1; k <= 8; k++) step(0, 1, (k == 1), 0, 1, 0, 0);
        chk("pre_rst_count", {24'b0, count}, 7);
        step(1, 1, 1, 0, 1, 1, 3);
        chk("midrst_out", {31'b0, out}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_count", {24'b0, count}, 0);
        for (int k = 1; k <= 11; k++) begin
            step(0, 1, (k == 1), 0, 1, 0, 0);
            chk("rstper_out", {31'b0, out}, (k == 11) ? 1 : 0);
        end
        chk("rstper_done", {31'b0, done}, 1);
        step(0, 1, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("p0_busy", {31'b0, busy}, 0);
        chk("p0_done_kept", {31'b0, done}, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("p0_busy_later", {31'b0, busy}, 0);

        // Random traffic against the model
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) == 0),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 12));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/prog_tick_gen.md
# prog_tick_gen

Programmable terminal-count tick generator: a WIDTH-bit up-counter with a run-time loadable period, periodic or one-shot mode, run/pause gating and a registered single-cycle tick output. It extends the fixed counter → constant-comparator → output-flop timer used in our lab designs. Typical uses are baud/sample-rate strobes and timeouts in downstream blocks.

## Interface
- WIDTH, 8: counter and period width in bits.
- RESET_PERIOD, 10: period loaded by reset; must satisfy 1 ≤ RESET_PERIOD ≤ 2^WIDTH−1.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; low freezes the counter (pause).
- start  input  1  strobe; begins counting from IDLE.
- stop  input  1  strobe; aborts counting, returns to IDLE.
- mode  input  1  0 = periodic, 1 = one-shot; sampled only when start is accepted.
- load  input  1  strobe; captures period_in.
- period_in  input  WIDTH  new period P in cycles.
- out  output  1  registered tick, one cycle wide per terminal count.
- count  output  WIDTH  current counter value.
- busy  output  1  high in RUN.
- done  output  1  one-shot completion flag, sticky.

## Operation
- Registers: state (IDLE/RUN), count, active period P_act, pending period P_pend + pending flag, latched mode, out, done.
- Reset: state IDLE, count 0, out 0, busy 0, done 0, P_act = RESET_PERIOD, pending cleared, mode latch 0.
- IDLE: count held at 0. start=1 and P_act≠0 → RUN, count 0, mode latched, done cleared. start with P_act=0 ignored (stays IDLE, done unchanged). en does not gate acceptance of start.
- RUN, en=1: if count == P_act−1 (wrap) → count 0, out=1 next cycle; otherwise count+1. Count arithmetic is modulo 2^WIDTH; no wrap beyond P_act−1 occurs.
- RUN, en=0: count, state frozen; no wrap, out 0.
- Periodic: stays in RUN after wrap. One-shot: wrap → IDLE and done=1, both visible alongside the out pulse.
- stop=1 in RUN → IDLE, count 0, no tick; stop beats a coinciding wrap (tick suppressed) and a coinciding start. stop in IDLE: no effect.
- start while in RUN: ignored (no restart, mode unchanged).
- load in IDLE: P_act = period_in next cycle. load in RUN: stored in P_pend, transferred to P_act at the next wrap (or at stop); the current period completes with the old value. Repeated loads: last one wins. load coinciding with wrap: the new value governs the period starting at that wrap.
- load of 0: accepted; once active, RUN counter wraps never and start is ignored; a periodic RUN that picks up P=0 at a wrap drops to IDLE.
- P=1: periodic out high every enabled cycle.
- done: set only by one-shot completion; cleared by accepted start or rst.

## Timing
- start sampled in cycle t → busy=1, count=0 in t+1; count = P−1 in cycle t+P; out=1 during t+P+1 (one-cycle registered latency after wrap, matching output flop).
- Periodic: subsequent out pulses every P enabled cycles; each paused cycle delays the next pulse by one.
- One-shot: busy falls and done rises in t+P+1, same cycle as out.
- stop in cycle s → busy=0, count=0 in s+1; out=0 in s+1.
- rst dominates all inputs in the same edge, including mid-period.

## Test plan
- Reset, then start with RESET_PERIOD=10, mode=0, en=1 → out pulses at cycles t+11, t+21, t+31; count sequence 0..9 repeating; done stays 0.
- load 4 in IDLE, start mode=1 → count 0,1,2,3; out, done high and busy low at t+5; further cycles no pulses; next start clears done.
- Periodic P=10, load 3 at count=5 → current period ends at count 9 with tick; following ticks every 3 cycles.
- Periodic P=6, drop en for 4 cycles at count=2 → count holds 2, out 0; tick arrives 4 cycles later than nominal.
- Periodic P=5, assert stop exactly on count=4 cycle with start also high → no tick, busy=0, count=0 next cycle.
- rst asserted at count=7 of P=10 one-shot → next cycle all outputs 0, P_act back to 10; load 0 then start → stays IDLE, busy 0.
